rpc_dqs_delay_trainer: RTL and testbench

- Sequencer that calibrates the 5-bit DQS input delay-line setting (phy_dqs_delay_cfg) of the RPC DRAM PHY.
- Sweeps every tap and, at each tap, issues test reads of a known pattern through a req/gnt port into the controller's command path.
- Records pass/fail per tap, finds the longest contiguous passing window and programs the delay line to the window centre.
- Sits between the register-bus config block (start/status) and the delay-config input of the PHY.

---
 rtl/rpc_config_path_pkg.sv | 14 +
 rtl/rpc_dqs_window_tracker.sv | 41 ++++
 rtl/rpc_dqs_delay_trainer.sv | 138 +++++++++++++
 tb/tb_rpc_dqs_delay_trainer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rpc_config_path_pkg.sv
// rpc_config_path_pkg: shared constants and state type for the RPC PHY config path
package rpc_config_path_pkg;
  localparam int DELAY_CFG_WIDTH = 5;
  localparam logic [15:0] DEFAULT_PATTERN = 16'hA55A;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_REQ,
    S_WAIT,
    S_EVAL,
    S_CENTER,
    S_DONE
  } state_t;
endpackage

// File: rtl/rpc_dqs_window_tracker.sv
// rpc_dqs_window_tracker: tracks the current passing run and the longest (earliest on tie) window
module rpc_dqs_window_tracker #(
  parameter int W = rpc_config_path_pkg::DELAY_CFG_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear,
  input  logic         en,
  input  logic         pass,
  input  logic         close,
  input  logic [W-1:0] tap,
  output logic [W-1:0] best_lo,
  output logic [W:0]   best_len
);
  localparam logic [W:0] ONE = 1;
  logic [W:0]   run_len, nxt_len;
  logic [W-1:0] run_start, nxt_start;
  logic         closing;
  // extend or open the run on pass; a fail or the last tap closes it
  always_comb begin
    nxt_len   = pass ? run_len + ONE : run_len;
    nxt_start = (pass && run_len == '0) ? tap : run_start;
    closing   = !pass || close;
  end
  // commit the run and promote it to best only when strictly longer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear) begin
      run_len   <= '0;
      run_start <= '0;
      best_lo   <= '0;
      best_len  <= '0;
    end else if (en) begin
      run_len   <= closing ? '0 : nxt_len;
      run_start <= nxt_start;
      if (closing && nxt_len > best_len) begin
        best_lo  <= nxt_start;
        best_len <= nxt_len;
      end
    end
  end
endmodule

// File: rtl/rpc_dqs_delay_trainer.sv
// rpc_dqs_delay_trainer: sweeps DQS delay taps with test reads and centres on the best window; RPC_DQS_TRAIN_MULTI_SAMPLE_EN gives 4 reads per tap
module rpc_dqs_delay_trainer #(
  parameter int                        DELAY_CFG_WIDTH = rpc_config_path_pkg::DELAY_CFG_WIDTH,
  parameter int                        DATA_WIDTH      = 16,
  parameter logic [DATA_WIDTH-1:0]     PATTERN         = rpc_config_path_pkg::DEFAULT_PATTERN,
  parameter logic [DELAY_CFG_WIDTH-1:0] DEFAULT_DELAY  = 8,
  parameter int                        SETTLE_CYCLES   = 8,
  parameter int                        TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       fail_o,
  output logic                       rd_req_o,
  input  logic                       rd_gnt_i,
  input  logic                       rd_valid_i,
  input  logic [DATA_WIDTH-1:0]      rd_data_i,
  output logic [DELAY_CFG_WIDTH-1:0] delay_cfg_o,
  output logic [DELAY_CFG_WIDTH-1:0] win_lo_o,
  output logic [DELAY_CFG_WIDTH-1:0] win_hi_o
);
  import rpc_config_path_pkg::*;
  localparam int W  = DELAY_CFG_WIDTH;
  localparam int CW = $clog2((TIMEOUT_CYCLES > SETTLE_CYCLES ? TIMEOUT_CYCLES : SETTLE_CYCLES) + 1);
  localparam logic [W:0] ONE = 1;
  state_t        state, state_nxt;
  logic [W-1:0]  tap, prev_cfg, best_lo, win_hi_c, center;
  logic [W:0]    best_len;
  logic [CW-1:0] cnt;
  logic          pass_r, match, last_tap, last_smp, settle_done, timeout, start_ok;
`ifdef RPC_DQS_TRAIN_MULTI_SAMPLE_EN
  logic [1:0]    smp;
  assign last_smp = &smp;
`else
  assign last_smp = 1'b1;
`endif
  assign match       = rd_data_i == PATTERN;
  assign last_tap    = &tap;
  assign settle_done = cnt == CW'(SETTLE_CYCLES - 1);
  assign timeout     = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign start_ok    = state == S_IDLE && start_i;
  assign win_hi_c    = W'({1'b0, best_lo} + best_len - ONE);
  assign center      = W'(({1'b0, best_lo} + {1'b0, win_hi_c}) >> 1);
  rpc_dqs_window_tracker #(.W(W)) u_tracker (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (start_ok),
    .en      (state == S_EVAL),
    .pass    (pass_r),
    .close   (last_tap),
    .tap     (tap),
    .best_lo (best_lo),
    .best_len(best_len)
  );
  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end
  // next-state and handshake/status outputs
  always_comb begin
    state_nxt = state;
    rd_req_o  = state == S_REQ;
    busy_o    = !(state == S_IDLE || state == S_DONE);
    case (state)
      S_IDLE:   state_nxt = start_i ? S_SETTLE : S_IDLE;
      S_SETTLE: state_nxt = settle_done ? S_REQ : S_SETTLE;
      S_REQ:    state_nxt = rd_gnt_i ? S_WAIT : S_REQ;
      S_WAIT:   state_nxt = rd_valid_i ? (last_smp ? S_EVAL : S_REQ) : (timeout ? S_EVAL : S_WAIT);
      S_EVAL:   state_nxt = last_tap ? S_CENTER : S_SETTLE;
      S_CENTER: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end
  // sweep datapath: counters, pass accumulation, delay programming and result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tap         <= '0;
      prev_cfg    <= '0;
      delay_cfg_o <= DEFAULT_DELAY;
      done_o      <= 1'b0;
      fail_o      <= 1'b0;
      win_lo_o    <= '0;
      win_hi_o    <= '0;
      cnt         <= '0;
      pass_r      <= 1'b0;
`ifdef RPC_DQS_TRAIN_MULTI_SAMPLE_EN
      smp         <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          prev_cfg    <= delay_cfg_o;
          delay_cfg_o <= '0;
          tap         <= '0;
          done_o      <= 1'b0;
          fail_o      <= 1'b0;
          cnt         <= '0;
        end
        S_SETTLE: begin
          cnt    <= settle_done ? '0 : cnt + CW'(1);
          pass_r <= 1'b1;
`ifdef RPC_DQS_TRAIN_MULTI_SAMPLE_EN
          smp    <= '0;
`endif
        end
        S_REQ: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          if (rd_valid_i) begin
            pass_r <= pass_r & match;
`ifdef RPC_DQS_TRAIN_MULTI_SAMPLE_EN
            smp    <= smp + 2'd1;
`endif
          end else if (timeout) pass_r <= 1'b0;
        end
        S_EVAL: begin
          cnt <= '0;
          if (!last_tap) begin
            tap         <= tap + W'(1);
            delay_cfg_o <= tap + W'(1);
          end
        end
        S_CENTER: begin
          done_o      <= 1'b1;
          fail_o      <= best_len == '0;
          win_lo_o    <= best_len != '0 ? best_lo : '0;
          win_hi_o    <= best_len != '0 ? win_hi_c : '0;
          delay_cfg_o <= best_len != '0 ? center : prev_cfg;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rpc_dqs_delay_trainer.sv
// tb_rpc_dqs_delay_trainer: directed checks of the DQS delay sweep, window centring and abort paths
module tb_rpc_dqs_delay_trainer;
  logic        clk_i = 0, rst_i = 1, start_i = 0;
  logic        busy_o, done_o, fail_o, rd_req_o;
  logic        rd_gnt_i = 0, rd_valid_i = 0;
  logic [15:0] rd_data_i = 0;
  logic [4:0]  delay_cfg_o, win_lo_o, win_hi_o;
  logic [31:0] mask = 0;
  int          drop = -1, gnt_dly = 1, req_run = 0, last_run = 0;
  int          passed = 0, total = 0;

  rpc_dqs_delay_trainer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .fail_o(fail_o), .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_valid_i(rd_valid_i),
    .rd_data_i(rd_data_i), .delay_cfg_o(delay_cfg_o), .win_lo_o(win_lo_o), .win_hi_o(win_hi_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] mk(input int lo, input int hi);
    logic [31:0] r = 0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  // command-path model: grant after gnt_dly cycles of request, data one cycle later
  initial forever begin
    @(negedge clk_i);
    if (rd_req_o && !rst_i) begin
      repeat (gnt_dly - 1) @(negedge clk_i);
      rd_gnt_i = 1;
      @(negedge clk_i);
      rd_gnt_i = 0;
      @(negedge clk_i);
      if (int'(delay_cfg_o) != drop) begin
        rd_valid_i = 1;
        rd_data_i  = mask[delay_cfg_o] ? 16'hA55A : 16'h5AA5;
        @(negedge clk_i);
        rd_valid_i = 0;
      end
    end
  end

  // length of the most recent rd_req_o high stretch
  initial forever begin
    @(negedge clk_i);
    if (rd_req_o) req_run++;
    else if (req_run > 0) begin
      last_run = req_run;
      req_run  = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
  endtask

  task automatic run_train(input logic [31:0] m, input int d, input int g, input bit mid);
    mask = m; drop = d; gnt_dly = g;
    @(negedge clk_i);
    start_i = 1;
    @(negedge clk_i);
    start_i = 0;
    for (int i = 0; i < 4000 && !done_o; i++) begin
      @(negedge clk_i);
      if (mid && i == 100) begin
        start_i = 1;
        @(negedge clk_i);
        start_i = 0;
        chk("busy_ignore", busy_o, 1);
      end
    end
    chk("done", done_o, 1);
    chk("busy_end", busy_o, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_fail", fail_o, 0);
    chk("rst_req", rd_req_o, 0);
    chk("rst_delay", delay_cfg_o, 8);
    chk("rst_lo", win_lo_o, 0);
    chk("rst_hi", win_hi_o, 0);
    rst_i = 0;

    run_train(mk(10, 20), -1, 1, 0);
    chk("w10_lo", win_lo_o, 10);
    chk("w10_hi", win_hi_o, 20);
    chk("w10_delay", delay_cfg_o, 15);
    chk("w10_fail", fail_o, 0);

    run_train(mk(3, 7) | mk(20, 24), -1, 1, 0);
    chk("tie_lo", win_lo_o, 3);
    chk("tie_hi", win_hi_o, 7);
    chk("tie_delay", delay_cfg_o, 5);

    run_train(mk(20, 26), -1, 1, 0);
    chk("w20_lo", win_lo_o, 20);
    chk("w20_hi", win_hi_o, 26);
    chk("w20_delay", delay_cfg_o, 23);

    do_reset();
    run_train(32'h0, -1, 1, 0);
    chk("none_fail", fail_o, 1);
    chk("none_delay", delay_cfg_o, 8);
    chk("none_lo", win_lo_o, 0);
    chk("none_hi", win_hi_o, 0);

    run_train(32'hFFFF_FFFF, -1, 1, 0);
    chk("all_lo", win_lo_o, 0);
    chk("all_hi", win_hi_o, 31);
    chk("all_delay", delay_cfg_o, 15);
    chk("all_fail", fail_o, 0);

    run_train(mk(28, 31), -1, 1, 0);
    chk("top_lo", win_lo_o, 28);
    chk("top_hi", win_hi_o, 31);
    chk("top_delay", delay_cfg_o, 29);

    run_train(mk(10, 20), 12, 5, 1);
    chk("to_lo", win_lo_o, 13);
    chk("to_hi", win_hi_o, 20);
    chk("to_delay", delay_cfg_o, 16);
    chk("gnt_req_len", last_run, 5);

    mask = mk(10, 20); drop = 7; gnt_dly = 1;
    @(negedge clk_i);
    start_i = 1;
    @(negedge clk_i);
    start_i = 0;
    for (int i = 0; i < 2000 && !(delay_cfg_o == 7 && rd_req_o); i++) @(negedge clk_i);
    for (int i = 0; i < 20 && rd_req_o; i++) @(negedge clk_i);
    chk("wait_reached", (delay_cfg_o == 7 && busy_o && !rd_req_o), 1);
    repeat (3) @(negedge clk_i);
    rst_i = 1;
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_req", rd_req_o, 0);
    chk("abort_delay", delay_cfg_o, 8);
    chk("abort_done", done_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    run_train(mk(10, 20), -1, 1, 0);
    chk("fresh_lo", win_lo_o, 10);
    chk("fresh_hi", win_hi_o, 20);
    chk("fresh_delay", delay_cfg_o, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
